// File: rtl/fp_square_seq_pkg.sv
// Shared definitions for the sequential float squarer and its rounding stage.
//   RND_*      rounding-mode codes carried in the top bits of each operand share
//   STAT_*     bit positions inside the optional 8-bit status vector
//   state_t    FSM encoding (S_IDLE / S_MUL / S_RND)
//   exp_bias() IEEE exponent bias for a given exponent width
package fp_square_seq_pkg;

    localparam logic [2:0] RND_RNE  = 3'd0;
    localparam logic [2:0] RND_RTZ  = 3'd1;
    localparam logic [2:0] RND_UP   = 3'd2;
    localparam logic [2:0] RND_DN   = 3'd3;
    localparam logic [2:0] RND_NUP  = 3'd4;
    localparam logic [2:0] RND_AWAY = 3'd5;

    localparam int STAT_ZERO    = 0;
    localparam int STAT_INF     = 1;
    localparam int STAT_INVALID = 2;
    localparam int STAT_TINY    = 3;
    localparam int STAT_HUGE    = 4;
    localparam int STAT_INEXACT = 5;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_RND  = 2'd2
    } state_t;

    function automatic int exp_bias(input int exp_width);
        return (1 << (exp_width - 1)) - 1;
    endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational normalise / round / clamp stage for a positive float result.
// Optional feature macro: FP_SQUARE_STATUS_EN (adds the status output).
// Ports:
//   prod     in   raw significand product, value in [1,4) with 2*SIG_W fraction bits
//   e2       in   biased exponent of the product before normalisation (signed)
//   rnd      in   rounding mode (RND_* codes; 6/7 act as RNE)
//   is_zero  in   operand was zero/denormal: force +0
//   is_inf   in   operand exponent was all ones: force +inf
//   result   out  packed IEEE result, sign always 0
//   status   out  (FP_SQUARE_STATUS_EN only) zero/inf/tiny/huge/inexact flags
module fp_round_norm
    import fp_square_seq_pkg::*;
#(
    parameter int SIG_W = 23,
    parameter int EXP_W = 8
) (
    input  logic [2*SIG_W+1:0]     prod,
    input  logic signed [EXP_W+1:0] e2,
    input  logic [2:0]             rnd,
    input  logic                   is_zero,
    input  logic                   is_inf,
    output logic [SIG_W+EXP_W:0]   result
`ifdef FP_SQUARE_STATUS_EN
    ,
    output logic [7:0]             status
`endif
);

    localparam int P = 2*SIG_W + 2;
    localparam logic signed [EXP_W+2:0] EXP_MAX = (EXP_W+3)'((1 << EXP_W) - 1);
    localparam logic [SIG_W+EXP_W:0] POS_INF = {1'b0, {EXP_W{1'b1}}, {SIG_W{1'b0}}};
    localparam logic [SIG_W+EXP_W:0] MAX_FIN = {1'b0, {(EXP_W-1){1'b1}}, 1'b0, {SIG_W{1'b1}}};

    logic                    hi;
    logic [SIG_W-1:0]        frac;
    logic                    guard;
    logic                    sticky;
    logic                    inc;
    logic [SIG_W+1:0]        mant;
    logic signed [EXP_W+2:0] exp_n;
    logic signed [EXP_W+2:0] exp_r;
    logic [SIG_W-1:0]        frac_r;
    logic                    ovf;
    logic                    unf;

    always_comb begin
        // A product >= 2 has its leading one one place higher: take the fraction
        // one bit further up and bump the exponent.
        hi = prod[P-1];
        if (hi) begin
            frac   = prod[P-2 -: SIG_W];
            guard  = prod[P-2-SIG_W];
            sticky = |prod[P-3-SIG_W:0];
        end else begin
            frac   = prod[P-3 -: SIG_W];
            guard  = prod[P-3-SIG_W];
            sticky = |prod[P-4-SIG_W:0];
        end

        // The result is always positive, so "toward -inf" truncates and
        // "toward +inf" rounds away from zero.
        case (rnd)
            RND_RTZ, RND_DN:  inc = 1'b0;
            RND_UP, RND_AWAY: inc = guard | sticky;
            RND_NUP:          inc = guard;
            default:          inc = guard & (sticky | frac[0]);
        endcase

        exp_n = $signed({e2[EXP_W+1], e2}) + $signed({{(EXP_W+2){1'b0}}, hi});
        mant  = {2'b01, frac} + {{(SIG_W+1){1'b0}}, inc};

        // Rounding carry out of 1.111..1 yields 10.000..0: renormalise.
        if (mant[SIG_W+1]) begin
            exp_r  = exp_n + (EXP_W+3)'(1);
            frac_r = mant[SIG_W:1];
        end else begin
            exp_r  = exp_n;
            frac_r = mant[SIG_W-1:0];
        end

        ovf = (exp_r >= EXP_MAX);
        unf = exp_r[EXP_W+2] | (exp_r == '0);

        if (is_zero) begin
            result = '0;
        end else if (is_inf) begin
            result = POS_INF;
        end else if (ovf) begin
            result = (rnd == RND_RTZ || rnd == RND_DN) ? MAX_FIN : POS_INF;
        end else if (unf) begin
            result = '0;
        end else begin
            result = {1'b0, exp_r[EXP_W-1:0], frac_r};
        end
    end

`ifdef FP_SQUARE_STATUS_EN
    always_comb begin
        status               = '0;
        status[STAT_ZERO]    = (result == '0);
        status[STAT_INF]     = (result == POS_INF);
        status[STAT_INVALID] = 1'b0;
        if (!is_zero && !is_inf) begin
            status[STAT_HUGE]    = ovf;
            status[STAT_TINY]    = unf & ~ovf;
            status[STAT_INEXACT] = guard | sticky | ovf | unf;
        end
    end
`endif

endmodule

// File: rtl/fp_square_seq.sv
// Sequential IEEE-754 squarer z = a*a with XOR-shared operand.
// The operand and rounding mode are recovered as g_input ^ e_input, layout {rnd[2:0], a}.
// A shift-add multiplier consumes one multiplier bit per cycle, so latency is fixed.
// Optional feature macro: FP_SQUARE_STATUS_EN (adds the registered status output).
// Ports:
//   clk      in   clock, rising edge
//   rst      in   asynchronous reset, active low
//   start    in   request; sampled only while idle
//   g_input  in   garbler share {rnd, a}
//   e_input  in   evaluator share {rnd, a}
//   busy     out  high from the cycle after start is accepted until done
//   done     out  one-cycle pulse, o valid
//   state    out  current FSM state (debug visibility)
//   o        out  squared result, held until the next done
//   status   out  (FP_SQUARE_STATUS_EN only) result flags, updated with o
//
// Handshake: start is a request without backpressure. It is accepted only on a
// cycle where state is S_IDLE (including the done cycle); any start seen while
// busy is dropped, never queued. Each accepted start produces exactly one done.
module fp_square_seq
    import fp_square_seq_pkg::*;
#(
    parameter int inst_sig_width       = 23,
    parameter int inst_exp_width       = 8,
    parameter int inst_ieee_compliance = 0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic                                      start,
    input  logic [inst_sig_width+inst_exp_width+3:0]  g_input,
    input  logic [inst_sig_width+inst_exp_width+3:0]  e_input,
    output logic                                      busy,
    output logic                                      done,
    output state_t                                    state,
    output logic [inst_sig_width+inst_exp_width:0]    o
`ifdef FP_SQUARE_STATUS_EN
    ,
    output logic [7:0]                                status
`endif
);

    localparam int S  = inst_sig_width;
    localparam int E  = inst_exp_width;
    localparam int W  = S + E + 1;
    localparam int P  = 2*(S + 1);
    localparam int CW = $clog2(S + 1);
    localparam logic [E+1:0]  BIAS    = (E+2)'(exp_bias(E));
    localparam logic [CW-1:0] CNT_TOP = CW'(S);

    logic [W+2:0]        shares;
    logic [E-1:0]        exp_f;
    logic [S-1:0]        frac_f;
    logic [2:0]          rnd_in;
    logic signed [E+1:0] e2_in;
    logic                unused_bits;

    logic [2:0]          rnd_q;
    logic [S:0]          sig_q;
    logic [S:0]          mplier;
    logic [P-1:0]        prod;
    logic [CW-1:0]       cnt;
    logic signed [E+1:0] e2_q;
    logic                zero_q;
    logic                inf_q;
    logic [S+1:0]        sum;
    logic [W-1:0]        round_result;
`ifdef FP_SQUARE_STATUS_EN
    logic [7:0]          round_status;
`endif

    assign shares = g_input ^ e_input;
    assign exp_f  = shares[W-2:S];
    assign frac_f = shares[S-1:0];
    assign rnd_in = shares[W+2:W];
    // The square of a biased exponent x is 2x - bias once re-biased.
    assign e2_in  = $signed({1'b0, exp_f, 1'b0} - BIAS);
    // The operand sign never affects a square, and only flush-to-zero mode exists.
    assign unused_bits = shares[W-1] ^ (inst_ieee_compliance != 0);

    // One LSB-first shift-add step: add the multiplicand into the upper half,
    // then shift the whole accumulator right by one.
    assign sum = {1'b0, prod[P-1:S+1]} + (mplier[0] ? {1'b0, sig_q} : '0);

    fp_round_norm #(
        .SIG_W (S),
        .EXP_W (E)
    ) u_round (
        .prod    (prod),
        .e2      (e2_q),
        .rnd     (rnd_q),
        .is_zero (zero_q),
        .is_inf  (inf_q),
        .result  (round_result)
`ifdef FP_SQUARE_STATUS_EN
        ,
        .status  (round_status)
`endif
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            o      <= '0;
            rnd_q  <= '0;
            sig_q  <= '0;
            mplier <= '0;
            prod   <= '0;
            cnt    <= '0;
            e2_q   <= '0;
            zero_q <= 1'b0;
            inf_q  <= 1'b0;
`ifdef FP_SQUARE_STATUS_EN
            status <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_MUL;
                        busy   <= 1'b1;
                        rnd_q  <= rnd_in;
                        sig_q  <= {1'b1, frac_f};
                        mplier <= {1'b1, frac_f};
                        prod   <= '0;
                        cnt    <= CNT_TOP;
                        e2_q   <= e2_in;
                        zero_q <= (exp_f == '0);
                        inf_q  <= (exp_f == '1);
                    end
                end
                S_MUL: begin
                    prod   <= {sum, prod[S:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= S_RND;
                    end
                end
                S_RND: begin
                    o     <= round_result;
`ifdef FP_SQUARE_STATUS_EN
                    status <= round_status;
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_square_seq.sv
module tb_fp_square_seq;
    import fp_square_seq_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic [34:0] g_input;
    logic [34:0] e_input;
    logic        busy;
    logic        done;
    state_t      state;
    logic [31:0] o;
`ifdef FP_SQUARE_STATUS_EN
    logic [7:0]  status;
`endif

    fp_square_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .g_input (g_input),
        .e_input (e_input),
        .busy    (busy),
        .done    (done),
        .state   (state),
        .o       (o)
`ifdef FP_SQUARE_STATUS_EN
        ,
        .status  (status)
`endif
    );

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [34:0] m;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    task automatic check_pop(input string tag);
        logic [31:0] w;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            w = exp_q.pop_front();
            check(tag, o, w);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input logic [31:0] a, input logic [2:0] rnd);
        m       = 35'({$urandom(), $urandom()});
        g_input = {rnd, a} ^ m;
        e_input = m;
    endtask

    // One full operation from idle: checks busy, done latency, single-cycle done, result.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [2:0] rnd,
                          input logic [31:0] want);
        int edges;
        @(negedge clk);
        drive(a, rnd);
        start = 1'b1;
        exp_q.push_back(want);
        @(posedge clk);
        #1 start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        edges = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (done) begin
                edges = k;
                break;
            end
        end
        check({tag, "_latency"}, 32'(edges), 32'd25);
        check_pop(tag);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1 check({tag, "_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n_done;
        rst     = 1'b0;
        start   = 1'b0;
        g_input = '0;
        e_input = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_o", o, 32'd0);
        check("rst_state", 32'(state), 32'(S_IDLE));
        @(negedge clk);
        rst = 1'b1;

        run_op("sq3",        32'h40400000, 3'd0, 32'h41100000);
        run_op("sqm2",       32'hC0000000, 3'd0, 32'h40800000);
        run_op("sq1p5",      32'h3FC00000, 3'd1, 32'h40100000);
        run_op("ulp_rne",    32'h3F800001, 3'd0, 32'h3F800002);
        run_op("ulp_up",     32'h3F800001, 3'd2, 32'h3F800003);
        run_op("ulp_rtz",    32'h3F800001, 3'd1, 32'h3F800002);
        run_op("ulp_dn",     32'h3F800001, 3'd3, 32'h3F800002);
        run_op("ulp_nup",    32'h3F800001, 3'd4, 32'h3F800002);
        run_op("ulp_away",   32'h3F800001, 3'd5, 32'h3F800003);
        run_op("ulp_r7",     32'h3F800001, 3'd7, 32'h3F800002);
        run_op("ovf_rne",    32'h7F000000, 3'd0, 32'h7F800000);
`ifdef FP_SQUARE_STATUS_EN
        check("stat_ovf_rne", 32'(status), 32'h32);
`endif
        run_op("ovf_rtz",    32'h7F000000, 3'd1, 32'h7F7FFFFF);
`ifdef FP_SQUARE_STATUS_EN
        check("stat_ovf_rtz", 32'(status), 32'h30);
`endif
        run_op("ovf_dn",     32'h7F000000, 3'd3, 32'h7F7FFFFF);
        run_op("ovf_away",   32'h7F000000, 3'd5, 32'h7F800000);
        run_op("inf_in",     32'hFF800000, 3'd1, 32'h7F800000);
        run_op("unf",        32'h1F800000, 3'd0, 32'h00000000);
        run_op("denorm",     32'h00400000, 3'd2, 32'h00000000);

        // Abort mid-multiply: outputs clear at once, no done afterwards.
        @(negedge clk);
        drive(32'h3FC00000, 3'd0);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_o", o, 32'd0);
        check("abort_state", 32'(state), 32'(S_IDLE));
        @(negedge clk);
        rst = 1'b1;
        n_done = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) n_done++;
        end
        check("abort_no_done", 32'(n_done), 32'd0);
        run_op("after_abort", 32'h40400000, 3'd0, 32'h41100000);

        // start held high through most of the busy period: one accepted request only.
        @(negedge clk);
        drive(32'hC0000000, 3'd1);
        start = 1'b1;
        exp_q.push_back(32'h40800000);
        n_done = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (k == 20) start = 1'b0;
            if (done) begin
                n_done++;
                check_pop("held_start");
            end
        end
        check("held_one_done", 32'(n_done), 32'd1);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
